// File: rtl/ped_crossing_if.sv
// ped_crossing_if: car-lamp inputs, pedestrian request and pedestrian-lamp outputs of the crossing controller
interface ped_crossing_if #(
    parameter int CW = 4
);
    logic          red;
    logic          orange;
    logic          green;
    logic          ped_btn;
    logic          walk;
    logic          dont_walk;
    logic          ped_wait;
    logic [CW-1:0] walk_remaining;
    logic          conflict;

    modport master (
        output red, orange, green, ped_btn,
        input  walk, dont_walk, ped_wait, walk_remaining, conflict
    );

    modport slave (
        input  red, orange, green, ped_btn,
        output walk, dont_walk, ped_wait, walk_remaining, conflict
    );
endinterface

// File: rtl/ped_crossing.sv
// ped_crossing: grants WALK inside the car red-only window after a clearance delay, then flashes DON'T WALK
module ped_crossing #(
    parameter int CLEAR_CYCLES = 1,
    parameter int WALK_CYCLES  = 4,
    parameter int FLASH_CYCLES = 4,
    parameter int CW           = 4
) (
    input logic          clk,
    input logic          rst,
    ped_crossing_if.slave bus
);
    localparam int CLW = $clog2(CLEAR_CYCLES + 2);
    localparam int FLW = $clog2(FLASH_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, CLEAR, WALK, FLASH} state_t;

    state_t         state_q;
    logic [CLW-1:0] clr_q;
    logic [FLW-1:0] fl_q;
    logic [CW-1:0]  rem_q;
    logic           walk_q;
    logic           dont_walk_q;
    logic           ped_wait_q;
    logic           conflict_q;
    logic           safe;

    assign safe = bus.red & ~bus.orange & ~bus.green;

    // Phase sequencer; clearance and flash counters count down so they stop at 1 and never wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            clr_q       <= '0;
            fl_q        <= '0;
            rem_q       <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            ped_wait_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            if (bus.green & (bus.red | bus.orange))
                conflict_q <= 1'b1;
            if (bus.ped_btn && state_q != WALK)
                ped_wait_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ped_wait_q && safe) begin
                        if (CLEAR_CYCLES == 0) begin
                            state_q     <= WALK;
                            walk_q      <= 1'b1;
                            dont_walk_q <= 1'b0;
                            rem_q       <= CW'(WALK_CYCLES);
                            ped_wait_q  <= 1'b0;
                        end else begin
                            state_q <= CLEAR;
                            clr_q   <= CLW'(CLEAR_CYCLES);
                        end
                    end
                end
                CLEAR: begin
                    if (!safe) begin
                        state_q <= IDLE;
                    end else if (clr_q <= CLW'(1)) begin
                        state_q     <= WALK;
                        walk_q      <= 1'b1;
                        dont_walk_q <= 1'b0;
                        rem_q       <= CW'(WALK_CYCLES);
                        ped_wait_q  <= 1'b0;
                    end else begin
                        clr_q <= clr_q - CLW'(1);
                    end
                end
                WALK: begin
                    if (bus.green) begin
                        state_q     <= IDLE;
                        conflict_q  <= 1'b1;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        rem_q       <= '0;
                    end else if (!safe || rem_q <= CW'(1)) begin
                        state_q     <= FLASH;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b0;
                        rem_q       <= '0;
                        fl_q        <= FLW'(FLASH_CYCLES);
                    end else begin
                        rem_q <= rem_q - CW'(1);
                    end
                end
                FLASH: begin
                    if (fl_q <= FLW'(1)) begin
                        state_q     <= IDLE;
                        dont_walk_q <= 1'b1;
                    end else begin
                        fl_q        <= fl_q - FLW'(1);
                        dont_walk_q <= ~dont_walk_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.walk           = walk_q;
    assign bus.dont_walk      = dont_walk_q;
    assign bus.ped_wait       = ped_wait_q;
    assign bus.walk_remaining = rem_q;
    assign bus.conflict       = conflict_q;
endmodule

// File: tb/tb_ped_crossing.sv
// tb_ped_crossing: directed scoreboard bench for the pedestrian crossing controller
module tb_ped_crossing;
    typedef struct packed {
        logic       walk;
        logic       dont_walk;
        logic       ped_wait;
        logic [3:0] rem;
        logic       conflict;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "reset";

    ped_crossing_if #(.CW(4)) bus ();

    ped_crossing #(
        .CLEAR_CYCLES(1),
        .WALK_CYCLES (4),
        .FLASH_CYCLES(4),
        .CW          (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare
    task automatic step(input logic rn, input logic r, input logic o, input logic g, input logic b,
                        input logic ew, input logic ed, input logic ep, input logic [3:0] er,
                        input logic ec);
        exp_t e;
        rst         = rn;
        bus.red     = r;
        bus.orange  = o;
        bus.green   = g;
        bus.ped_btn = b;
        sb_q.push_back({ew, ed, ep, er, ec});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({phase, ".walk"}, 32'(bus.walk), 32'(e.walk));
        check({phase, ".dont_walk"}, 32'(bus.dont_walk), 32'(e.dont_walk));
        check({phase, ".ped_wait"}, 32'(bus.ped_wait), 32'(e.ped_wait));
        check({phase, ".walk_remaining"}, 32'(bus.walk_remaining), 32'(e.rem));
        check({phase, ".conflict"}, 32'(bus.conflict), 32'(e.conflict));
    endtask

    initial begin
        bus.red = 0; bus.orange = 0; bus.green = 0; bus.ped_btn = 0;
        //    rn r o g b   walk dw wait rem conf
        step(0, 0, 0, 1, 1,  0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1,  0, 1, 0, 0, 0);

        phase = "nominal";
        step(1, 0, 0, 0, 1,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 3, 0);
        step(1, 1, 0, 0, 1,  1, 0, 0, 2, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);

        phase = "cutoff";
        step(1, 1, 0, 0, 1,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 3, 0);
        step(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);

        phase = "abort";
        step(1, 0, 0, 0, 1,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 4, 0);

        phase = "conflict";
        step(1, 0, 0, 1, 0,  0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0,  0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);

        phase = "flash_btn";
        step(1, 1, 0, 0, 1,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 3, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 2, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1,  0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 4, 0);
        step(1, 1, 0, 0, 0,  1, 0, 0, 3, 0);

        phase = "midreset";
        step(0, 1, 0, 0, 1,  0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
